cursor_box_renderer: RTL and testbench
======================================

Name: cursor_box_renderer

Overview:
- Pixel-colour stage directly downstream of the pixel-index-to-coordinate converter on the 96x64 OLED path.
- Consumes the current (X, Y) pixel coordinate and returns a registered 16-bit RGB565 colour.
- Draws a square cursor box that a button-driven direction state machine moves across the screen.
- Position updates are committed only at frame start, so a frame never shows a partly moved box (no tearing).

Parameters:
- BOX_SIZE, 8: box edge length in pixels (2..64).
- STEP_DIV, 1000000: clk cycles per 1-pixel movement step (>=2).
- FG_COLOUR, 16'h07E0: box interior colour.
- BORDER_COLOUR, 16'hFFFF: colour of the 1-pixel box outline.
- BG_COLOUR, 16'h0000: colour of every pixel outside the box.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn_u / btn_d / btn_l / btn_r  in  1 each  debounced level inputs, one per direction.
- btn_c  in  1  debounced level input, stop.
- frame_begin  in  1  one-cycle pulse at the start of each OLED frame.
- x_coord  in  8  current pixel column, 0..95.
- y_coord  in  8  current pixel row, 0..63.
- pixel_data  out  16  RGB565 colour for (x_coord, y_coord) as sampled one cycle earlier.
- box_x  out  7  committed box left column.
- box_y  out  6  committed box top row.
- moving  out  1  high when the FSM is in any MOVE state.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - pixel_data = BG_COLOUR, moving = 0.
  - box_x = pend_x = (96-BOX_SIZE)/2; box_y = pend_y = (64-BOX_SIZE)/2 (44, 28 for the default size).
  - Step counter = 0, FSM in IDLE, button edge registers = 0.
- Edge detection: each button is registered once per cycle; a rise is cur & ~prev.
- Step tick: the counter runs 0..STEP_DIV-1 continuously; step_tick is high in the cycle the count is STEP_DIV-1, then the count wraps to 0. The counter is never cleared except by reset.
- FSM states: IDLE, MV_U, MV_D, MV_L, MV_R.
  - Any state + btn_c rise -> IDLE. This overrides every other rise.
  - Any state + a direction rise -> the matching MV state. This applies even mid-move; last press wins.
  - Simultaneous direction rises resolve by priority U > D > L > R.
  - MV state + step_tick:
    - If the pending position is not at its limit, move it 1 pixel in the state's direction.
    - If it is at its limit, make no change and go to IDLE.
  - Limits: pend_x 0..96-BOX_SIZE; pend_y 0..64-BOX_SIZE. The pending position never leaves this range; no wrap-around.
  - A rise and a step_tick in the same cycle: the transition takes effect; the step is applied using the NEW direction.
- Commit: on a frame_begin cycle, box_x/box_y <= pend_x/pend_y as they were before that cycle's update. A step in the same cycle appears at the next frame.
- Pixel colour (registered, 1-cycle latency from x_coord/y_coord):
  - Inside the box: box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE.
  - BORDER_COLOUR on the outermost 1-pixel ring inside the box.
  - FG_COLOUR elsewhere inside the box.
  - BG_COLOUR outside the box, and for any x >= 96 or y >= 64.
- Arithmetic: all comparisons are unsigned and at least 8 bits wide, with no truncation of box_x+BOX_SIZE.
- Reset mid-move: returns the block to the reset state in the next cycle; the pending step is discarded.

Test Plan:
- Common bench settings: STEP_DIV=4, BOX_SIZE=8.
1. Reset held 3 cycles then released -> box_x=44, box_y=28, moving=0, pixel_data=16'h0000.
2. btn_r pulse, then a frame_begin after 3 step_ticks -> moving=1; after that frame_begin box_x=47, box_y=28.
3. btn_l held from box_x=1, stepping -> pend_x reaches 0; the next step_tick gives FSM IDLE, moving=0, and pend_x stays 0 (no wrap to 88).
4. btn_u and btn_r rise in the same cycle -> MV_U chosen; btn_c and btn_d rise together -> IDLE.
5. With box at (44,28): drive (44,28) -> 16'hFFFF; (45,29) -> 16'h07E0; (52,28) -> 16'h0000; (95,63) -> 16'h0000. Each colour appears exactly one cycle after its coordinate.
6. Steps accumulate mid-frame with no frame_begin -> box_x unchanged. Assert rst_n=0 during MV_R -> next cycle box_x=44, moving=0.

Source files
------------

// File: rtl/cursor_box_renderer.sv
// Cursor box renderer for the 96x64 OLED pixel path: colours each (x, y)
// with a movable square box, one registered cycle after the coordinate.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   btn_u/d/l/r, btn_c  debounced direction / stop levels
//   frame_begin         one-cycle pulse at frame start (commits position)
//   x_coord, y_coord    current pixel coordinate
//   pixel_data          RGB565 colour of the previous cycle's coordinate
//   box_x, box_y        committed box top-left corner
//   moving              high while the direction FSM is in a MOVE state
module cursor_box_renderer #(
    parameter int          BOX_SIZE      = 8,
    parameter int          STEP_DIV      = 1000000,
    parameter logic [15:0] FG_COLOUR     = 16'h07E0,
    parameter logic [15:0] BORDER_COLOUR = 16'hFFFF,
    parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_c,
    input  logic        frame_begin,
    input  logic [7:0]  x_coord,
    input  logic [7:0]  y_coord,
    output logic [15:0] pixel_data,
    output logic [6:0]  box_x,
    output logic [5:0]  box_y,
    output logic        moving
);

    localparam int             CNT_W    = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [6:0]     X_MAX    = 7'(96 - BOX_SIZE);
    localparam logic [5:0]     Y_MAX    = 6'(64 - BOX_SIZE);
    localparam logic [6:0]     X_HOME   = 7'((96 - BOX_SIZE) / 2);
    localparam logic [5:0]     Y_HOME   = 6'((64 - BOX_SIZE) / 2);
    localparam logic [8:0]     SIZE     = 9'(BOX_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        MV_U,
        MV_D,
        MV_L,
        MV_R
    } state_t;

    state_t            state;
    state_t            dir;
    state_t            state_next;
    logic [4:0]        btn_cur;
    logic [4:0]        btn_prev;
    logic [4:0]        rise;
    logic [CNT_W-1:0]  cnt;
    logic              step_tick;
    logic [6:0]        pend_x;
    logic [5:0]        pend_y;
    logic [6:0]        pend_x_next;
    logic [5:0]        pend_y_next;

    // Bit order: stop, up, down, left, right.
    assign btn_cur   = {btn_c, btn_u, btn_d, btn_l, btn_r};
    assign rise      = btn_cur & ~btn_prev;
    assign step_tick = (cnt == CNT_LAST);
    assign moving    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev <= '0;
            cnt      <= '0;
            state    <= IDLE;
            pend_x   <= X_HOME;
            pend_y   <= Y_HOME;
            box_x    <= X_HOME;
            box_y    <= Y_HOME;
        end else begin
            btn_prev <= btn_cur;
            cnt      <= step_tick ? '0 : cnt + CNT_W'(1);
            state    <= state_next;
            pend_x   <= pend_x_next;
            pend_y   <= pend_y_next;
            // Commit the pre-update pending position: a step taken in
            // this same cycle only shows up at the next frame.
            if (frame_begin) begin
                box_x <= pend_x;
                box_y <= pend_y;
            end
        end
    end

    // Stop beats every direction; among directions U > D > L > R.
    always_comb begin
        dir = state;
        if (rise[4])      dir = IDLE;
        else if (rise[3]) dir = MV_U;
        else if (rise[2]) dir = MV_D;
        else if (rise[1]) dir = MV_L;
        else if (rise[0]) dir = MV_R;
    end

    // A step in the same cycle as a new press uses the new direction.
    always_comb begin
        state_next  = dir;
        pend_x_next = pend_x;
        pend_y_next = pend_y;
        if (step_tick) begin
            case (dir)
                MV_U: begin
                    if (pend_y == '0) state_next = IDLE;
                    else              pend_y_next = pend_y - 6'd1;
                end
                MV_D: begin
                    if (pend_y == Y_MAX) state_next = IDLE;
                    else                 pend_y_next = pend_y + 6'd1;
                end
                MV_L: begin
                    if (pend_x == '0) state_next = IDLE;
                    else              pend_x_next = pend_x - 7'd1;
                end
                MV_R: begin
                    if (pend_x == X_MAX) state_next = IDLE;
                    else                 pend_x_next = pend_x + 7'd1;
                end
                default: ;
            endcase
        end
    end

    // 9-bit compare so box_x + BOX_SIZE can never truncate.
    logic [8:0]  px, py, bx0, by0, bx1, by1;
    logic        on_screen, in_box, on_ring;
    logic [15:0] colour;

    always_comb begin
        px        = {1'b0, x_coord};
        py        = {1'b0, y_coord};
        bx0       = {2'b0, box_x};
        by0       = {3'b0, box_y};
        bx1       = bx0 + SIZE - 9'd1;
        by1       = by0 + SIZE - 9'd1;
        on_screen = (px < 9'd96) && (py < 9'd64);
        in_box    = on_screen && (px >= bx0) && (px <= bx1) &&
                    (py >= by0) && (py <= by1);
        on_ring   = (px == bx0) || (px == bx1) ||
                    (py == by0) || (py == by1);
        colour    = BG_COLOUR;
        if (in_box) colour = on_ring ? BORDER_COLOUR : FG_COLOUR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pixel_data <= BG_COLOUR;
        else        pixel_data <= colour;
    end

endmodule

// File: tb/tb_cursor_box_renderer.sv
// Directed bench for cursor_box_renderer (STEP_DIV=4, BOX_SIZE=8).
// Steps land on edges that are multiples of 4 after the last reset edge.
module tb_cursor_box_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_u = 1'b0;
    logic        btn_d = 1'b0;
    logic        btn_l = 1'b0;
    logic        btn_r = 1'b0;
    logic        btn_c = 1'b0;
    logic        frame_begin = 1'b0;
    logic [7:0]  x_coord = 8'd0;
    logic [7:0]  y_coord = 8'd0;
    logic [15:0] pixel_data;
    logic [6:0]  box_x;
    logic [5:0]  box_y;
    logic        moving;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    cursor_box_renderer #(
        .BOX_SIZE (8),
        .STEP_DIV (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .btn_c       (btn_c),
        .frame_begin (frame_begin),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .pixel_data  (pixel_data),
        .box_x       (box_x),
        .box_y       (box_y),
        .moving      (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, ncyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic go_to(input int n);
        while (ncyc < n) tick();
    endtask

    // Pulse frame_begin in the cycle after edge n; commit at edge n+1.
    task automatic frame_at(input int n);
        go_to(n);
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ncyc  = 0;
    endtask

    logic [7:0]  px_x [12];
    logic [7:0]  px_y [12];
    logic [15:0] px_c [12];

    initial begin
        px_x = '{8'd44, 8'd45, 8'd52, 8'd95, 8'd51, 8'd51,
                 8'd43, 8'd48, 8'd50, 8'd44, 8'd200, 8'd46};
        px_y = '{8'd28, 8'd29, 8'd28, 8'd63, 8'd35, 8'd36,
                 8'd30, 8'd33, 8'd34, 8'd35, 8'd30, 8'd31};
        px_c = '{16'hFFFF, 16'h07E0, 16'h0000, 16'h0000,
                 16'hFFFF, 16'h0000, 16'h0000, 16'h07E0,
                 16'h07E0, 16'hFFFF, 16'h0000, 16'h07E0};

        // 1: reset state
        do_reset(3);
        check("rst_box_x", 32'(box_x), 32'd44);
        check("rst_box_y", 32'(box_y), 32'd28);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_pixel", 32'(pixel_data), 32'h0000);

        // 2: move right, 3 steps (edges 4, 8, 12), commit at edge 13
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
        check("r_moving", 32'(moving), 32'd1);
        go_to(12);
        check("r_no_commit", 32'(box_x), 32'd44);
        frame_at(12);
        check("r_box_x", 32'(box_x), 32'd47);
        check("r_box_y", 32'(box_y), 32'd28);
        btn_c = 1'b1;
        tick();
        btn_c = 1'b0;
        check("c_stop", 32'(moving), 32'd0);

        // 3: hold left from 47; pend 1 at edge 196, 0 at 200, idle 204
        btn_l = 1'b1;
        tick();
        frame_at(196);
        check("l_box_x1", 32'(box_x), 32'd1);
        frame_at(200);
        check("l_box_x0", 32'(box_x), 32'd0);
        check("l_moving", 32'(moving), 32'd1);
        go_to(204);
        check("l_limit_idle", 32'(moving), 32'd0);
        frame_at(208);
        check("l_no_wrap", 32'(box_x), 32'd0);

        // 4: U and R together -> up; C and D together -> stop
        go_to(210);
        btn_l = 1'b0;
        btn_u = 1'b1;
        btn_r = 1'b1;
        tick();
        btn_u = 1'b0;
        btn_r = 1'b0;
        check("ur_moving", 32'(moving), 32'd1);
        frame_at(212);
        check("ur_box_y", 32'(box_y), 32'd27);
        check("ur_box_x", 32'(box_x), 32'd0);
        btn_c = 1'b1;
        btn_d = 1'b1;
        tick();
        btn_c = 1'b0;
        btn_d = 1'b0;
        check("cd_idle", 32'(moving), 32'd0);
        frame_at(216);
        check("cd_box_y", 32'(box_y), 32'd27);

        // 5: colours with box at (44,28); sampled after the next coord
        //    is already applied so only a 1-cycle latency matches
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            x_coord = px_x[i];
            y_coord = px_y[i];
            #1;
            if (i > 0)
                check($sformatf("pix%0d", i - 1),
                      32'(pixel_data), 32'(px_c[i - 1]));
            tick();
        end

        // 6: commit one step right, then reset mid-move
        go_to(13);
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
        frame_at(16);
        check("r2_box_x", 32'(box_x), 32'd45);
        check("r2_moving", 32'(moving), 32'd1);
        go_to(21);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ncyc  = 0;
        check("mid_rst_box_x", 32'(box_x), 32'd44);
        check("mid_rst_box_y", 32'(box_y), 32'd28);
        check("mid_rst_moving", 32'(moving), 32'd0);
        frame_at(5);
        check("mid_rst_pend", 32'(box_x), 32'd44);
        check("mid_rst_still", 32'(moving), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
